// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked multi-cycle ALU (ADD/AND/NOT/PASSA/OR/XOR/SHL/MUL) with NZP and carry.
// Optional iterative multiplier is built only when ALU_SEQ_MUL_EN is defined.
module alu_seq #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       aluk,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic [2:0]       out_nzp,
    output logic             out_illegal
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_MUL, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             illegal_q, illegal_d;
    logic             valid_q, valid_d;
    logic             ready_q, ready_d;
    logic [2:0]       nzp_q, nzp_d;
    logic [WIDTH:0]   sum;
    logic             finish;
`ifdef ALU_SEQ_MUL_EN
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] acc_q, acc_d;
`endif

    function automatic logic [2:0] nzp_of(input logic [WIDTH-1:0] r);
        if (r[WIDTH-1])     return 3'b100;
        else if (r == '0)   return 3'b010;
        else                return 3'b001;
    endfunction

    always_comb begin
        state_d   = state_q;
        opa_d     = opa_q;
        result_d  = result_q;
        cnt_d     = cnt_q;
        carry_d   = carry_q;
        illegal_d = illegal_q;
        valid_d   = valid_q;
        ready_d   = ready_q;
        nzp_d     = nzp_q;
        finish    = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        opb_d     = opb_q;
        acc_d     = acc_q;
`endif
        sum = {1'b0, a} + {1'b0, b};

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    carry_d   = 1'b0;
                    illegal_d = 1'b0;
                    case (aluk)
                        3'b000: begin
                            result_d = sum[WIDTH-1:0];
                            carry_d  = sum[WIDTH];
                            finish   = 1'b1;
                        end
                        3'b001: begin result_d = a & b; finish = 1'b1; end
                        3'b010: begin result_d = ~a;    finish = 1'b1; end
                        3'b011: begin result_d = a;     finish = 1'b1; end
                        3'b100: begin result_d = a | b; finish = 1'b1; end
                        3'b101: begin result_d = a ^ b; finish = 1'b1; end
                        3'b110: begin
                            if (b[SHW-1:0] == '0) begin
                                result_d = a;
                                finish   = 1'b1;
                            end else begin
                                opa_d   = a;
                                cnt_d   = CW'(b[SHW-1:0]);
                                ready_d = 1'b0;
                                state_d = S_SHIFT;
                            end
                        end
                        default: begin
`ifdef ALU_SEQ_MUL_EN
                            opa_d   = a;
                            opb_d   = b;
                            acc_d   = '0;
                            cnt_d   = CW'(WIDTH);
                            ready_d = 1'b0;
                            state_d = S_MUL;
`else
                            result_d  = '0;
                            illegal_d = 1'b1;
                            finish    = 1'b1;
`endif
                        end
                    endcase
                end
            end
            S_SHIFT: begin
                opa_d = opa_q << 1;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    result_d = opa_q << 1;
                    finish   = 1'b1;
                end
            end
`ifdef ALU_SEQ_MUL_EN
            S_MUL: begin
                // Shift-add, multiplier LSB first; high product bits fall off the top.
                acc_d = acc_q + (opb_q[0] ? opa_q : '0);
                opa_d = opa_q << 1;
                opb_d = opb_q >> 1;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    result_d = acc_d;
                    finish   = 1'b1;
                end
            end
`endif
            S_DONE: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    ready_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
                valid_d = 1'b0;
            end
        endcase

        if (finish) begin
            nzp_d   = nzp_of(result_d);
            valid_d = 1'b1;
            ready_d = 1'b0;
            state_d = S_DONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            opa_q     <= '0;
            result_q  <= '0;
            cnt_q     <= '0;
            carry_q   <= 1'b0;
            illegal_q <= 1'b0;
            valid_q   <= 1'b0;
            ready_q   <= 1'b1;
            nzp_q     <= 3'b000;
`ifdef ALU_SEQ_MUL_EN
            opb_q     <= '0;
            acc_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            opa_q     <= opa_d;
            result_q  <= result_d;
            cnt_q     <= cnt_d;
            carry_q   <= carry_d;
            illegal_q <= illegal_d;
            valid_q   <= valid_d;
            ready_q   <= ready_d;
            nzp_q     <= nzp_d;
`ifdef ALU_SEQ_MUL_EN
            opb_q     <= opb_d;
            acc_q     <= acc_d;
`endif
        end
    end

    assign in_ready    = ready_q;
    assign out_valid   = valid_q;
    assign out_result  = result_q;
    assign out_carry   = carry_q;
    assign out_nzp     = nzp_q;
    assign out_illegal = illegal_q;
endmodule
